// File: rtl/cen24_gen_pkg.sv
// Shared types for the 24 MHz clock-enable generator.
// Counter geometry and the registered strobe bundle.
package cen24_gen_pkg;

    localparam int CNT16_W   = 4;
    localparam int CNT16_MOD = 16;
    localparam int CNT6_W    = 3;
    localparam int CNT6_MOD  = 6;

    typedef struct packed {
        logic cen12;
        logic cen8;
        logic cen6;
        logic cen4;
        logic cen3;
        logic cen3q;
        logic cen1p5;
        logic cen12b;
        logic cen6b;
        logic cen3b;
        logic cen3qb;
        logic cen1p5b;
    } cen_t;

endpackage

// File: rtl/cen24_gen_counter.sv
// Free-running modulo-N up counter.
// Clears asynchronously and wraps from MOD-1 to 0.
module cen24_gen_counter #(
    parameter int W   = 4,
    parameter int MOD = 16
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] q_o
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q + W'(1);
        if (q_q == LAST) begin
            q_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/cen24_gen.sv
// Clock-enable strobes at 12/8/6/4/3/1.5 MHz from a 24 MHz clock,
// with 180-degree and quarter-period-advanced variants.
module cen24_gen
    import cen24_gen_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output logic cen12,
    output logic cen8,
    output logic cen6,
    output logic cen4,
    output logic cen3,
    output logic cen3q,
    output logic cen1p5,
    output logic cen12b,
    output logic cen6b,
    output logic cen3b,
    output logic cen3qb,
    output logic cen1p5b
);

    logic [CNT16_W-1:0] cnt16;
    logic [CNT6_W-1:0]  cnt6;

    cen_t cen_q;
    cen_t cen_d;

    cen24_gen_counter #(
        .W   (CNT16_W),
        .MOD (CNT16_MOD)
    ) u_cnt16 (
        .clk (clk),
        .rst (rst),
        .q_o (cnt16)
    );

    cen24_gen_counter #(
        .W   (CNT6_W),
        .MOD (CNT6_MOD)
    ) u_cnt6 (
        .clk (clk),
        .rst (rst),
        .q_o (cnt6)
    );

    // Strobes decode the counter value before this edge's increment.
    always_comb begin
        cen_d         = '0;
        cen_d.cen12   = (cnt16[0] == 1'b0);
        cen_d.cen12b  = (cnt16[0] == 1'b1);
        cen_d.cen6    = (cnt16[1:0] == 2'd0);
        cen_d.cen6b   = (cnt16[1:0] == 2'd2);
        cen_d.cen3    = (cnt16[2:0] == 3'd0);
        cen_d.cen3b   = (cnt16[2:0] == 3'd4);
        cen_d.cen3q   = (cnt16[2:0] == 3'd6);
        cen_d.cen3qb  = (cnt16[2:0] == 3'd2);
        cen_d.cen1p5  = (cnt16 == 4'd0);
        cen_d.cen1p5b = (cnt16 == 4'd8);
        cen_d.cen8    = (cnt6 == 3'd0) || (cnt6 == 3'd3);
        cen_d.cen4    = (cnt6 == 3'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cen_q <= '0;
        end else begin
            cen_q <= cen_d;
        end
    end

    assign cen12   = cen_q.cen12;
    assign cen8    = cen_q.cen8;
    assign cen6    = cen_q.cen6;
    assign cen4    = cen_q.cen4;
    assign cen3    = cen_q.cen3;
    assign cen3q   = cen_q.cen3q;
    assign cen1p5  = cen_q.cen1p5;
    assign cen12b  = cen_q.cen12b;
    assign cen6b   = cen_q.cen6b;
    assign cen3b   = cen_q.cen3b;
    assign cen3qb  = cen_q.cen3qb;
    assign cen1p5b = cen_q.cen1p5b;

endmodule

// File: tb/tb_cen24_gen.sv
// Randomized self-checking bench for cen24_gen against a
// period/phase model counted in edges since reset release.
module tb_cen24_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cen12, cen8, cen6, cen4, cen3, cen3q, cen1p5;
    logic cen12b, cen6b, cen3b, cen3qb, cen1p5b;

    int n_cmp = 0;
    int n_err = 0;
    int k     = 0;

    // Periods in clk, in the same order as the observed vector.
    localparam int PER [12] = '{2, 3, 4, 6, 8, 8, 16, 2, 4, 8, 8, 16};

    always #5 clk = ~clk;

    cen24_gen dut (
        .clk     (clk),
        .rst     (rst),
        .cen12   (cen12),
        .cen8    (cen8),
        .cen6    (cen6),
        .cen4    (cen4),
        .cen3    (cen3),
        .cen3q   (cen3q),
        .cen1p5  (cen1p5),
        .cen12b  (cen12b),
        .cen6b   (cen6b),
        .cen3b   (cen3b),
        .cen3qb  (cen3qb),
        .cen1p5b (cen1p5b)
    );

    wire [11:0] obs = {cen12, cen8, cen6, cen4, cen3, cen3q, cen1p5,
                       cen12b, cen6b, cen3b, cen3qb, cen1p5b};

    // Edge k after release: each strobe fires when (k-1) lands on
    // its phase within its period.
    function automatic logic [11:0] exp_vec(int e);
        int p;
        p = e - 1;
        return {p % 2 == 0, p % 3 == 0, p % 4 == 0, p % 6 == 0,
                p % 8 == 0, p % 8 == 6, p % 16 == 0,
                p % 2 == 1, p % 4 == 2, p % 8 == 4, p % 8 == 2,
                p % 16 == 8};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        k = 0;
    endtask

    task automatic test_reset();
        int hold;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== 12'h000) begin
            n_err++;
            $display("FAIL reset_async obs=%b exp=%b", obs, 12'h000);
        end
        hold = 10;
        for (int i = 0; i < hold; i++) begin
            step();
            n_cmp++;
            if (obs !== 12'h000) begin
                n_err++;
                $display("FAIL reset_hold cyc=%0d obs=%b exp=%b",
                         i, obs, 12'h000);
            end
        end
    endtask

    task automatic test_first_edge();
        release_rst();
        step();
        n_cmp++;
        if (obs !== 12'b111110100000) begin
            n_err++;
            $display("FAIL first_edge obs=%b exp=%b",
                     obs, 12'b111110100000);
        end
    endtask

    task automatic test_periods();
        int cnt [12];
        int last [12];
        rst = 1'b1;
        step();
        release_rst();
        for (int i = 0; i < 12; i++) begin
            cnt[i]  = 0;
            last[i] = -1;
        end
        for (int c = 0; c < 96; c++) begin
            step();
            for (int i = 0; i < 12; i++) begin
                if (obs[11-i] === 1'b1) begin
                    if (last[i] >= 0) begin
                        n_cmp++;
                        if (k - last[i] != PER[i]) begin
                            n_err++;
                            $display("FAIL spacing bit=%0d got=%0d exp=%0d",
                                     i, k - last[i], PER[i]);
                        end
                    end
                    last[i] = k;
                    cnt[i]++;
                end
            end
        end
        for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if (cnt[i] != 96 / PER[i]) begin
                n_err++;
                $display("FAIL pulse_count bit=%0d got=%0d exp=%0d",
                         i, cnt[i], 96 / PER[i]);
            end
        end
    endtask

    task automatic run_model(int n);
        logic [11:0] e;
        for (int c = 0; c < n; c++) begin
            step();
            e = exp_vec(k);
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL phase edge=%0d obs=%b exp=%b", k, obs, e);
            end
        end
    endtask

    task automatic test_phases();
        run_model(int'($urandom_range(40, 200)));
    endtask

    task automatic test_nesting();
        logic bad;
        int n;
        n = int'($urandom_range(50, 150));
        for (int c = 0; c < n; c++) begin
            step();
            bad = (cen12 & cen12b) | (cen6 & cen6b) | (cen3 & cen3b)
                | (cen3q & cen3qb) | (cen1p5 & cen1p5b)
                | (cen1p5 & ~cen3) | (cen3 & ~cen6) | (cen6 & ~cen12)
                | (cen4 & ~cen8) | (cen3q & ~cen12) | (cen3q & ~cen6b);
            n_cmp++;
            if (bad !== 1'b0) begin
                n_err++;
                $display("FAIL nesting edge=%0d obs=%b", k, obs);
            end
        end
    endtask

    task automatic reset_burst(int lag, int hold);
        #(lag);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== 12'h000) begin
            n_err++;
            $display("FAIL async_drop edge=%0d obs=%b exp=%b",
                     k, obs, 12'h000);
        end
        for (int i = 0; i < hold; i++) begin
            step();
            n_cmp++;
            if (obs !== 12'h000) begin
                n_err++;
                $display("FAIL reset_held obs=%b exp=%b", obs, 12'h000);
            end
        end
        release_rst();
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        step();
        release_rst();
        run_model(37);
        reset_burst(4, int'($urandom_range(1, 5)));
        run_model(20);
    endtask

    task automatic test_random_resets();
        for (int r = 0; r < 6; r++) begin
            run_model(int'($urandom_range(1, 60)));
            reset_burst(int'($urandom_range(1, 7)),
                        int'($urandom_range(0, 4)));
        end
        run_model(int'($urandom_range(16, 48)));
    endtask

    initial begin
        test_reset();
        test_first_edge();
        test_periods();
        test_phases();
        test_nesting();
        test_mid_reset();
        test_random_resets();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
